// File: rtl/hex_fill_scheduler.sv
// hex_fill_scheduler
//   Shares one hex-fill engine between NUM_REQ requesters. An idle cycle
//   arbitrates round-robin and latches the winning center/radius. The filled
//   hex disc is then streamed out one axial cell per cycle under valid/ready.
//   Cells are ordered dq outer ascending and dr inner ascending. Each cell
//   carries its hex distance from the center as depth.
//
// Ports
//   clk, reset       clock, asynchronous active-high reset
//   req_valid/ready  per-requester handshake; ready is one-hot for one cycle
//   req_q/r/radius   per-requester center (16-bit signed) and radius (4-bit)
//   abort            drop the job being emitted
//   cell_valid/ready cell stream handshake
//   cell_q/r         cell coordinates, 16-bit two's-complement wrap
//   cell_depth       hex distance of the cell from the center
//   cell_src         id of the requester owning the job
//   cell_first/last  job framing
//   cell_idx         0-based cell index within the job
//   busy             high while a job is being emitted
module hex_fill_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int MAX_RADIUS = 7,
    parameter int SRC_W      = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0][15:0] req_q,
    input  logic [NUM_REQ-1:0][15:0] req_r,
    input  logic [NUM_REQ-1:0][3:0]  req_radius,
    input  logic                     abort,
    output logic                     cell_valid,
    input  logic                     cell_ready,
    output logic signed [15:0]       cell_q,
    output logic signed [15:0]       cell_r,
    output logic [7:0]               cell_depth,
    output logic [SRC_W-1:0]         cell_src,
    output logic                     cell_first,
    output logic                     cell_last,
    output logic [7:0]               cell_idx,
    output logic                     busy
);

    localparam logic [3:0] MAX_R = 4'(MAX_RADIUS);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t                   state_q, state_d;
    logic [SRC_W-1:0]         ptr_q, ptr_d;
    logic [SRC_W-1:0]         src_q, src_d;
    logic [15:0]              qc_q, qc_d;
    logic [15:0]              rc_q, rc_d;
    logic [3:0]               rad_q, rad_d;
    logic signed [5:0]        dq_q, dq_d;
    logic signed [5:0]        dr_q, dr_d;
    logic [7:0]               idx_q, idx_d;

    logic [SRC_W-1:0]         grant;
    logic [SRC_W-1:0]         cand;
    logic                     any_valid;
    logic [3:0]               rad_new;
    logic signed [5:0]        r_new_s;
    logic signed [5:0]        r_s;
    logic signed [5:0]        dq_inc;
    logic                     last_cell;
    logic signed [6:0]        sum7;
    logic [6:0]               mag_q, mag_r, mag_s, depth_full;

    function automatic logic signed [5:0] smax(input logic signed [5:0] a,
                                               input logic signed [5:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [5:0] smin(input logic signed [5:0] a,
                                               input logic signed [5:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [6:0] mag(input logic signed [6:0] v);
        return (v < 0) ? 7'(-v) : 7'(v);
    endfunction

    // (a + b) mod NUM_REQ for b < NUM_REQ; one extra bit holds the carry.
    function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] a,
                                                  input int unsigned     b);
        logic [SRC_W:0] s;
        s = {1'b0, a} + (SRC_W+1)'(b);
        if (s >= (SRC_W+1)'(NUM_REQ)) begin
            s = s - (SRC_W+1)'(NUM_REQ);
        end
        return s[SRC_W-1:0];
    endfunction

    // Round-robin pick: scan offsets from far to near so the requester
    // closest to the pointer (smallest offset) is the one left standing.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            cand = wrap_add(ptr_q, k - 1);
            if (req_valid[cand]) begin
                grant     = cand;
                any_valid = 1'b1;
            end
        end
    end

    assign rad_new   = (req_radius[grant] > MAX_R) ? MAX_R : req_radius[grant];
    assign r_new_s   = $signed({2'b00, rad_new});
    assign r_s       = $signed({2'b00, rad_q});
    assign dq_inc    = dq_q + 6'sd1;
    assign last_cell = (dq_q == r_s) && (dr_q == r_s - dq_q);

    // Next-state and handshake logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        src_d     = src_q;
        qc_d      = qc_q;
        rc_d      = rc_q;
        rad_d     = rad_q;
        dq_d      = dq_q;
        dr_d      = dr_q;
        idx_d     = idx_q;
        req_ready = '0;

        unique case (state_q)
            IDLE: begin
                if (any_valid && !reset) begin
                    req_ready = NUM_REQ'(1) << grant;
                    qc_d      = req_q[grant];
                    rc_d      = req_r[grant];
                    src_d     = grant;
                    rad_d     = rad_new;
                    dq_d      = -r_new_s;
                    dr_d      = smax(-r_new_s, -r_new_s + r_new_s);
                    idx_d     = '0;
                    ptr_d     = wrap_add(grant, 1);
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cell_ready) begin
                    if (last_cell) begin
                        state_d = IDLE;
                    end else begin
                        if (dr_q == smin(r_s, r_s - dq_q)) begin
                            dq_d = dq_inc;
                            dr_d = smax(-r_s, -r_s - dq_inc);
                        end else begin
                            dr_d = dr_q + 6'sd1;
                        end
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Cell outputs derive from the job registers and read zero outside EMIT.
    always_comb begin
        sum7       = 7'(dq_q) + 7'(dr_q);
        mag_q      = mag(7'(dq_q));
        mag_r      = mag(7'(dr_q));
        mag_s      = mag(sum7);
        depth_full = mag_q;
        if (mag_r > depth_full) depth_full = mag_r;
        if (mag_s > depth_full) depth_full = mag_s;

        cell_valid = 1'b0;
        busy       = 1'b0;
        cell_q     = '0;
        cell_r     = '0;
        cell_depth = '0;
        cell_src   = '0;
        cell_first = 1'b0;
        cell_last  = 1'b0;
        cell_idx   = '0;
        if (state_q == EMIT) begin
            cell_valid = 1'b1;
            busy       = 1'b1;
            cell_q     = qc_q + 16'(dq_q);
            cell_r     = rc_q + 16'(dr_q);
            cell_depth = {1'b0, depth_full};
            cell_src   = src_q;
            cell_first = (idx_q == 8'd0);
            cell_last  = last_cell;
            cell_idx   = idx_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            src_q   <= '0;
            qc_q    <= '0;
            rc_q    <= '0;
            rad_q   <= '0;
            dq_q    <= '0;
            dr_q    <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            qc_q    <= qc_d;
            rc_q    <= rc_d;
            rad_q   <= rad_d;
            dq_q    <= dq_d;
            dr_q    <= dr_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: doc/hex_fill_scheduler.md
Name: hex_fill_scheduler

Overview:
- Shares one hex-fill engine between NUM_REQ requesters (e.g. primitive setup lanes).
- Arbitrates round-robin, latches the winning center and radius, then streams the filled hex disc out serially, one axial cell per cycle, under valid/ready backpressure.
- Serial cell order is identical to the parallel fill array order: dq outer ascending, dr inner ascending.
- Each cell carries its hex distance from the center as depth, feeding the downstream per-cell depth/shading stage.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_RADIUS, 7, largest supported radius; larger requests are clamped to it.
- SRC_W, $clog2(NUM_REQ), width of the requester id.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  [NUM_REQ]  per-requester request valid.
- req_ready  out  [NUM_REQ]  per-requester accept (one-hot or zero).
- req_q  in  [NUM_REQ][16] signed  rounded center q per requester.
- req_r  in  [NUM_REQ][16] signed  rounded center r per requester.
- req_radius  in  [NUM_REQ][4]  requested radius per requester.
- abort  in  1  drop the current job.
- cell_valid  out  1  cell output valid.
- cell_ready  in  1  downstream accept.
- cell_q  out  16 signed  cell q.
- cell_r  out  16 signed  cell r.
- cell_depth  out  8  hex distance from center.
- cell_src  out  SRC_W  id of the owning requester.
- cell_first  out  1  first cell of the job.
- cell_last  out  1  last cell of the job.
- cell_idx  out  8  0-based index of the cell within the job.
- busy  out  1  high in EMIT.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state IDLE, round-robin pointer 0;
  - cell_valid, busy, cell_first, cell_last = 0;
  - cell_q, cell_r, cell_depth, cell_idx, cell_src = 0;
  - req_ready = 0.
- FSM has two states: IDLE and EMIT.
- IDLE:
  - If any req_valid is high, grant the first valid requester at or after the pointer, in circular order.
  - req_ready[grant] = 1 combinationally in that cycle only; all other req_ready bits are 0.
  - On the grant, latch:
    - center (qc, rc) and src = grant;
    - R = min(req_radius, MAX_RADIUS);
    - dq = -R, dr = max(-R, -R-dq);
    - idx = 0.
  - Pointer becomes grant+1 mod NUM_REQ. Next state is EMIT.
  - req_ready is never asserted outside IDLE.
- EMIT:
  - cell_valid = 1, with:
    - cell_q = qc+dq and cell_r = rc+dr, both 16-bit two's-complement wrap, no saturation;
    - cell_depth = max(|dq|, |dr|, |dq+dr|);
    - cell_first = (idx==0);
    - cell_last = (dq==R and dr==R-dq).
  - A cell transfers when cell_valid && cell_ready.
  - On transfer, if not last:
    - if dr == min(R, R-dq): dq++, then dr = max(-R, -R-dq_new);
    - else dr++;
    - idx++.
  - On transfer of the last cell, next state is IDLE.
  - Without a transfer, every cell_* output holds stable.
- Latency: request accepted at cycle T gives first cell valid at T+1. One idle cycle separates back-to-back jobs (the arbitration cycle).
- Cells per job = 1+3R(R+1); 169 at R=7, so idx fits in 8 bits. R=0 gives a single cell with first=last=1 and depth 0.
- abort in EMIT: state goes to IDLE next cycle and cell_valid drops, even if a transfer occurs in the same cycle. abort in IDLE is ignored and does not block a grant in that cycle.
- Arithmetic: dq and dr are signed and at least 5 bits wide. Depth is computed at full width, then zero-extended to 8 bits.
- busy = (state==EMIT).
- Reset asserted mid-job discards the job immediately. No req_ready is pulsed while reset is high.

Test Plan:
- Requester 1 sends q=5, r=-3, radius=1, cell_ready held high:
  - req_ready[1] pulses one cycle; 7 cells follow on consecutive cycles.
  - (q,r,depth) in order: (4,-3,1) (4,-2,1) (5,-4,1) (5,-3,0) (5,-2,1) (6,-4,1) (6,-3,1).
  - first on idx 0, last on idx 6, src=1.
- All 4 requesters valid continuously with radius 0:
  - grants come in order 0,1,2,3,0;
  - each job is one cell with first=last=1 and depth 0;
  - one idle cycle between jobs.
- Radius 2, cell_ready toggled 1,0,0,1,...:
  - outputs stay stable while cell_ready is low;
  - exactly 19 cells are delivered, idx 0..18, depth-2 count = 12, no cell lost or duplicated.
- q=32767, r=-32768, radius=1:
  - cells include q=-32768 (wrap) and r=32767 (wrap);
  - depths match the unwrapped dq/dr.
- radius=9 with MAX_RADIUS=7: 169 cells, last cell at dq=7, dr=0, depth 7.
- abort at idx 4 of a radius-1 job: cell_valid is low the next cycle, state is IDLE, and a pending requester is granted in that following cycle. The same scenario with reset asserted instead gives all outputs 0 and the pointer back to 0.
